hazard_scoreboard: RTL and testbench

- Parametrised successor to the single-cycle load-use hazard detector in the ID stage of the pipelined CPU.
- Keeps a per-register countdown scoreboard of in-flight results with variable producer latency: loads, multi-cycle mul/div, and cache-miss loads.
- Decides issue or stall for the instruction in ID and drives PC write, IF/ID write and the bubble mux.
- Adds external pipeline freeze, ID squash, a WAW interlock and a saturating stall-cycle counter.

---
 rtl/hazard_pkg.sv | 36 +++
 rtl/hazard_sb_entry.sv | 41 ++++
 rtl/hazard_scoreboard.sv | 115 +++++++++++
 tb/tb_hazard_scoreboard.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared constants for the hazard scoreboard
//
// Purpose: default widths, the hard-wired zero register index and the
// producer latencies per operation class.
// Ports: none (package).
package hazard_pkg;

  localparam int DEF_REG_ADDR_W = 5;
  localparam int DEF_LAT_W      = 3;
  localparam int DEF_CNT_W      = 16;

  localparam int ZERO_REG = 0;

  // Cycles until a producer's result can be forwarded to a consumer in ID.
  localparam int LAT_ALU  = 0;
  localparam int LAT_LOAD = 1;
  localparam int LAT_MUL  = 3;
  localparam int LAT_DIV  = 7;

  typedef enum logic [1:0] {
    OP_ALU,
    OP_LOAD,
    OP_MUL,
    OP_DIV
  } opClassE;

  function automatic int latFor(opClassE op);
    case (op)
      OP_LOAD: return LAT_LOAD;
      OP_MUL:  return LAT_MUL;
      OP_DIV:  return LAT_DIV;
      default: return LAT_ALU;
    endcase
  endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// rtl/hazard_sb_entry.sv - one countdown register of the hazard scoreboard
//
// Purpose: tracks how many cycles remain before one register's pending
// result becomes forwardable.
// Ports:
//   clk      in   clock, rising edge
//   rstN     in   asynchronous reset, active-low
//   load     in   start a new countdown from loadVal
//   loadVal  in   new countdown value
//   hold     in   freeze the count (pipeline frozen)
//   pending  out  count is nonzero
//   count    out  remaining cycles
module hazard_sb_entry #(
  parameter int LAT_W = 3
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             load,
  input  logic [LAT_W-1:0] loadVal,
  input  logic             hold,
  output logic             pending,
  output logic [LAT_W-1:0] count
);

  // Hold beats load: a frozen pipeline accepts nothing. Load beats the
  // decrement so a re-issued producer restarts its full latency.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      count <= '0;
    end else if (hold) begin
      count <= count;
    end else if (load) begin
      count <= loadVal;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign pending = (count != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - ID-stage issue/stall decision with latency scoreboard
//
// Purpose: per-register countdown of in-flight results; stalls the ID
// instruction on RAW (rs/rt) or WAW (rd) against a pending entry.
// Ports:
//   clk_i            in   clock
//   rst_i            in   asynchronous reset, active-low
//   issue_valid_i    in   ID holds a valid instruction
//   issue_rs_i/rt_i  in   source registers
//   issue_rs_used_i  in   instruction reads rs
//   issue_rt_used_i  in   instruction reads rt
//   issue_wr_en_i    in   instruction writes rd
//   issue_rd_i       in   destination register
//   issue_lat_i      in   producer latency
//   freeze_i         in   external pipeline freeze
//   flush_i          in   ID instruction squashed
//   PC_Write_o       out  PC may update
//   IFID_Write_o     out  IF/ID may update
//   MUX8_o           out  inject bubble into ID/EX
//   stall_cnt_o      out  saturating hazard stall-cycle count
//   busy_o           out  any entry pending
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int NUM_REGS   = 2 ** REG_ADDR_W,
  parameter int LAT_W      = DEF_LAT_W,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  issue_valid_i,
  input  logic [REG_ADDR_W-1:0] issue_rs_i,
  input  logic [REG_ADDR_W-1:0] issue_rt_i,
  input  logic                  issue_rs_used_i,
  input  logic                  issue_rt_used_i,
  input  logic                  issue_wr_en_i,
  input  logic [REG_ADDR_W-1:0] issue_rd_i,
  input  logic [LAT_W-1:0]      issue_lat_i,
  input  logic                  freeze_i,
  input  logic                  flush_i,
  output logic                  PC_Write_o,
  output logic                  IFID_Write_o,
  output logic                  MUX8_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic                  busy_o
);

  logic [LAT_W-1:0]      remVec [NUM_REGS];
  logic [NUM_REGS-1:0]   pendVec;
  logic [REG_ADDR_W-1:0] zeroReg;
  logic                  hazA, hazB, hazC;
  logic                  hazard;
  logic                  freezeEff;
  logic                  accept;
  logic [CNT_W-1:0]      stallCnt;

  assign zeroReg = REG_ADDR_W'(ZERO_REG);

  // Register 0 is hard-wired: never pending, no storage.
  assign remVec[0]  = '0;
  assign pendVec[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
    hazard_sb_entry #(
      .LAT_W(LAT_W)
    ) u_entry (
      .clk     (clk_i),
      .rstN    (rst_i),
      .load    (accept & issue_wr_en_i & (issue_rd_i == REG_ADDR_W'(r))),
      .loadVal (issue_lat_i),
      .hold    (freeze_i),
      .pending (pendVec[r]),
      .count   (remVec[r])
    );
  end

  assign hazA = issue_rs_used_i & (issue_rs_i != zeroReg) & (remVec[issue_rs_i] != '0);
  assign hazB = issue_rt_used_i & (issue_rt_i != zeroReg) & (remVec[issue_rt_i] != '0);
  assign hazC = issue_wr_en_i   & (issue_rd_i != zeroReg) & (remVec[issue_rd_i] != '0);

  assign hazard = issue_valid_i & ~flush_i & (hazA | hazB | hazC);
  assign accept = issue_valid_i & ~flush_i & ~hazard & ~freeze_i;

  // While reset is asserted the outputs must read as "free-running", even
  // if the memory system happens to be holding freeze high.
  assign freezeEff = freeze_i & rst_i;

  always_comb begin
    PC_Write_o   = 1'b1;
    IFID_Write_o = 1'b1;
    MUX8_o       = 1'b0;
    if (freezeEff) begin
      PC_Write_o   = 1'b0;
      IFID_Write_o = 1'b0;
      MUX8_o       = 1'b0;
    end else begin
      PC_Write_o   = ~hazard;
      IFID_Write_o = ~hazard;
      MUX8_o       = hazard;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stallCnt <= '0;
    end else if (hazard && !freeze_i && (stallCnt != '1)) begin
      stallCnt <= stallCnt + CNT_W'(1);
    end
  end

  assign stall_cnt_o = stallCnt;
  assign busy_o      = |pendVec;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  typedef struct {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       rsu;
    logic       rtu;
    logic       we;
    logic [4:0] rd;
    logic [2:0] lat;
    logic       frz;
    logic       fl;
    logic       ePC;
    logic       eMux;
    logic       eBusy;
    int         eCnt;
  } vec_t;

  logic       clk;
  logic       rstN;
  logic       valid, rsU, rtU, wrEn, freeze, flush;
  logic [4:0] rs, rt, rd;
  logic [2:0] lat;

  logic        pcW, ifidW, mux8, busy;
  logic [15:0] cnt16;
  logic        pcW2, ifidW2, mux2, busy2;
  logic [3:0]  cnt4;

  int passCnt  = 0;
  int totalCnt = 0;

  int remM [32];
  int cntM;

  vec_t tbl [$];

  hazard_scoreboard #(.CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rstN),
    .issue_valid_i(valid), .issue_rs_i(rs), .issue_rt_i(rt),
    .issue_rs_used_i(rsU), .issue_rt_used_i(rtU),
    .issue_wr_en_i(wrEn), .issue_rd_i(rd), .issue_lat_i(lat),
    .freeze_i(freeze), .flush_i(flush),
    .PC_Write_o(pcW), .IFID_Write_o(ifidW), .MUX8_o(mux8),
    .stall_cnt_o(cnt16), .busy_o(busy)
  );

  hazard_scoreboard #(.CNT_W(4)) dutSat (
    .clk_i(clk), .rst_i(rstN),
    .issue_valid_i(valid), .issue_rs_i(rs), .issue_rt_i(rt),
    .issue_rs_used_i(rsU), .issue_rt_used_i(rtU),
    .issue_wr_en_i(wrEn), .issue_rd_i(rd), .issue_lat_i(lat),
    .freeze_i(freeze), .flush_i(flush),
    .PC_Write_o(pcW2), .IFID_Write_o(ifidW2), .MUX8_o(mux2),
    .stall_cnt_o(cnt4), .busy_o(busy2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(string name, longint act, longint exp);
    totalCnt++;
    if (act == exp) passCnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic vec_t mk(logic v, logic [4:0] rsI, logic [4:0] rtI, logic rsuI, logic rtuI,
                              logic weI, logic [4:0] rdI, logic [2:0] latI, logic frzI, logic flI,
                              logic ePC, logic eMux, logic eBusy, int eCnt);
    vec_t e;
    e.v = v; e.rs = rsI; e.rt = rtI; e.rsu = rsuI; e.rtu = rtuI; e.we = weI;
    e.rd = rdI; e.lat = latI; e.frz = frzI; e.fl = flI;
    e.ePC = ePC; e.eMux = eMux; e.eBusy = eBusy; e.eCnt = eCnt;
    return e;
  endfunction

  task automatic setIn(vec_t e);
    valid = e.v; rs = e.rs; rt = e.rt; rsU = e.rsu; rtU = e.rtu;
    wrEn = e.we; rd = e.rd; lat = e.lat; freeze = e.frz; flush = e.fl;
  endtask

  task automatic setIdle();
    setIn(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic modelReset();
    foreach (remM[r]) remM[r] = 0;
    cntM = 0;
  endtask

  // Reference: an instruction must wait while any register it reads or
  // writes still has cycles outstanding.
  function automatic bit modelHaz();
    bit a, b, c;
    a = rsU  && (rs != 0) && (remM[rs] > 0);
    b = rtU  && (rt != 0) && (remM[rt] > 0);
    c = wrEn && (rd != 0) && (remM[rd] > 0);
    return valid && !flush && (a || b || c);
  endfunction

  function automatic bit modelBusy();
    for (int r = 1; r < 32; r++) if (remM[r] > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic modelAdvance(bit h);
    bit acc;
    if (!freeze) begin
      acc = valid && !flush && !h;
      for (int r = 1; r < 32; r++) begin
        if (acc && wrEn && (rd == r)) remM[r] = int'(lat);
        else if (remM[r] > 0) remM[r] = remM[r] - 1;
      end
      if (h) cntM++;
    end
  endtask

  // Called at posedge+1 with inputs already driven; checks, then crosses one edge.
  task automatic runStep(string tag, bit useVec, vec_t e);
    bit h;
    int exp16, exp4;
    #2;
    h = modelHaz();
    if (useVec) begin
      check({tag, " pc"},   pcW,   e.ePC);
      check({tag, " ifid"}, ifidW, e.ePC);
      check({tag, " mux8"}, mux8,  e.eMux);
      check({tag, " busy"}, busy,  e.eBusy);
      check({tag, " cnt"},  cnt16, e.eCnt);
    end else begin
      exp16 = (cntM > 65535) ? 65535 : cntM;
      exp4  = (cntM > 15) ? 15 : cntM;
      check({tag, " pc"},    pcW,   freeze ? 0 : !h);
      check({tag, " ifid"},  ifidW, freeze ? 0 : !h);
      check({tag, " mux8"},  mux8,  freeze ? 0 : h);
      check({tag, " busy"},  busy,  modelBusy());
      check({tag, " cnt"},   cnt16, exp16);
      check({tag, " cnt4"},  cnt4,  exp4);
      check({tag, " mux8b"}, mux2,  freeze ? 0 : h);
    end
    @(posedge clk);
    modelAdvance(h);
    #1;
  endtask

  task automatic modelStep(string tag, vec_t e);
    setIn(e);
    runStep(tag, 1'b0, e);
  endtask

  initial begin
    vec_t idleV, divV, lwWaw;
    // lw/add, mul/sub, independent, $0, WAW, freeze, flush
    tbl.push_back(mk(1, 1, 0, 1, 0, 1, 8, LAT_LOAD, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 8, 1, 1, 1, 1, 9, LAT_ALU, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(1, 8, 1, 1, 1, 1, 9, LAT_ALU, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(1, 2, 3, 1, 1, 1, 10, LAT_MUL, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(1, 4, 10, 1, 1, 1, 11, LAT_ALU, 0, 0, 0, 1, 1, 1));
    tbl.push_back(mk(1, 4, 10, 1, 1, 1, 11, LAT_ALU, 0, 0, 0, 1, 1, 2));
    tbl.push_back(mk(1, 4, 10, 1, 1, 1, 11, LAT_ALU, 0, 0, 0, 1, 1, 3));
    tbl.push_back(mk(1, 4, 10, 1, 1, 1, 11, LAT_ALU, 0, 0, 1, 0, 0, 4));
    tbl.push_back(mk(1, 2, 3, 1, 1, 1, 10, LAT_MUL, 0, 0, 1, 0, 0, 4));
    tbl.push_back(mk(1, 2, 3, 1, 1, 1, 12, LAT_ALU, 0, 0, 1, 0, 1, 4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4));
    tbl.push_back(mk(1, 1, 2, 1, 1, 1, 0, LAT_DIV, 0, 0, 1, 0, 0, 4));
    tbl.push_back(mk(1, 0, 0, 1, 1, 1, 13, LAT_ALU, 0, 0, 1, 0, 0, 4));
    tbl.push_back(mk(1, 1, 2, 1, 1, 1, 5, LAT_DIV, 0, 0, 1, 0, 0, 4));
    for (int k = 0; k < 7; k++)
      tbl.push_back(mk(1, 1, 0, 1, 0, 1, 5, LAT_LOAD, 0, 0, 0, 1, 1, 4 + k));
    tbl.push_back(mk(1, 1, 0, 1, 0, 1, 5, LAT_LOAD, 0, 0, 1, 0, 0, 11));
    tbl.push_back(mk(1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 11));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 12));
    tbl.push_back(mk(1, 1, 0, 1, 0, 1, 8, LAT_LOAD, 0, 0, 1, 0, 0, 12));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(1, 8, 0, 1, 0, 1, 9, LAT_ALU, 1, 0, 0, 0, 1, 12));
    tbl.push_back(mk(1, 8, 0, 1, 0, 1, 9, LAT_ALU, 0, 0, 0, 1, 1, 12));
    tbl.push_back(mk(1, 8, 0, 1, 0, 1, 9, LAT_ALU, 0, 0, 1, 0, 0, 13));
    tbl.push_back(mk(1, 1, 0, 1, 0, 1, 8, LAT_LOAD, 0, 0, 1, 0, 0, 13));
    tbl.push_back(mk(1, 8, 0, 1, 0, 1, 7, 5, 0, 1, 1, 0, 1, 13));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 13));

    idleV = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    divV  = mk(1, 1, 2, 1, 1, 1, 5, LAT_DIV, 0, 0, 0, 0, 0, 0);
    lwWaw = mk(1, 1, 0, 1, 0, 1, 5, LAT_LOAD, 0, 0, 0, 0, 0, 0);

    // Reset state, with a would-be dependent instruction presented.
    setIdle();
    valid = 1'b1; rs = 5'd8; rsU = 1'b1;
    rstN = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    check("reset pc",   pcW,   1);
    check("reset ifid", ifidW, 1);
    check("reset mux8", mux8,  0);
    check("reset busy", busy,  0);
    check("reset cnt",  cnt16, 0);
    setIdle();
    rstN = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      setIn(tbl[i]);
      runStep($sformatf("tbl%0d", i), 1'b1, tbl[i]);
    end

    for (int i = 0; i < 400; i++) begin
      valid  = ($urandom_range(0, 9) < 8);
      rs     = 5'($urandom_range(0, 7));
      rt     = 5'($urandom_range(0, 7));
      rd     = 5'($urandom_range(0, 7));
      rsU    = 1'($urandom_range(0, 1));
      rtU    = 1'($urandom_range(0, 1));
      wrEn   = 1'($urandom_range(0, 1));
      lat    = 3'($urandom_range(0, 7));
      freeze = ($urandom_range(0, 9) == 0);
      flush  = ($urandom_range(0, 9) == 0);
      runStep($sformatf("rnd%0d", i), 1'b0, idleV);
    end

    // Mid-countdown reset: rem[5] = 5 with a dependent instruction waiting.
    for (int i = 0; i < 8; i++) modelStep("drain", idleV);
    modelStep("mr div", divV);
    modelStep("mr idle0", idleV);
    modelStep("mr idle1", idleV);
    check("mr cnt nonzero", (cnt16 != 0), 1);
    valid = 1'b1; rs = 5'd5; rsU = 1'b1;
    #2;
    rstN = 1'b0;
    #1;
    check("mr busy", busy,  0);
    check("mr cnt",  cnt16, 0);
    check("mr cnt4", cnt4,  0);
    check("mr pc",   pcW,   1);
    check("mr mux8", mux8,  0);
    modelReset();
    setIdle();
    @(posedge clk);
    #1;
    rstN = 1'b1;

    // Saturation: three div/WAW-load rounds give 21 hazard cycles.
    for (int k = 0; k < 3; k++) begin
      modelStep($sformatf("sat%0d div", k), divV);
      for (int j = 0; j < 7; j++) modelStep($sformatf("sat%0d s%0d", k, j), lwWaw);
    end
    check("sat cnt4", cnt4,  15);
    check("sat cnt16", cnt16, 21);
    modelStep("sat issue", lwWaw);
    modelStep("sat tail", idleV);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
